// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter merging two single-word req/ack requesters onto one sdram controller port.
// Optional watchdog abort of a stalled access: define SDRAM_ARB_TIMEOUT_EN.
module sdram_port_arbiter #(
    parameter int ADDR_W         = 24,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,

    input  logic [ADDR_W-1:0] a_address,
    input  logic [DATA_W-1:0] a_data_in,
    input  logic              a_read_req,
    input  logic              a_write_req,
    output logic              a_read_ack,
    output logic              a_write_ack,
    output logic [DATA_W-1:0] a_data_out,

    input  logic [ADDR_W-1:0] b_address,
    input  logic [DATA_W-1:0] b_data_in,
    input  logic              b_read_req,
    input  logic              b_write_req,
    output logic              b_read_ack,
    output logic              b_write_ack,
    output logic [DATA_W-1:0] b_data_out,

    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_data_in,
    output logic              m_read_req,
    output logic              m_write_req,
    input  logic              m_read_ack,
    input  logic              m_write_ack,
    input  logic [DATA_W-1:0] m_data_out,

    output logic              busy,
    output logic              grant_b,
    output logic              err_timeout
);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t state, state_nxt;

    logic last_grant;
    logic cur_wr;
    logic pend_a, pend_b;
    logic grant_fire, pick_b, pick_wr;
    logic op_ack, done, load_rdata;
    logic timeout_hit;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_fire) state_nxt = BUSY;
            BUSY:    if (done)       state_nxt = RELEASE;
            RELEASE:                 state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Tie-break favours the port that did not own the last transaction; writes beat reads within a port.
    always_comb begin
        pend_a     = a_read_req | a_write_req;
        pend_b     = b_read_req | b_write_req;
        grant_fire = (state == IDLE) && (pend_a || pend_b);
        pick_b     = pend_b && (!pend_a || !last_grant);
        pick_wr    = pick_b ? b_write_req : a_write_req;
        op_ack     = cur_wr ? m_write_ack : m_read_ack;
        done       = (state == BUSY) && (op_ack || timeout_hit);
        load_rdata = done && !cur_wr && op_ack;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_address   <= '0;
            m_data_in   <= '0;
            m_read_req  <= 1'b0;
            m_write_req <= 1'b0;
            a_read_ack  <= 1'b0;
            a_write_ack <= 1'b0;
            b_read_ack  <= 1'b0;
            b_write_ack <= 1'b0;
            a_data_out  <= '0;
            b_data_out  <= '0;
            grant_b     <= 1'b0;
            last_grant  <= 1'b1;
            cur_wr      <= 1'b0;
        end else begin
            a_read_ack  <= 1'b0;
            a_write_ack <= 1'b0;
            b_read_ack  <= 1'b0;
            b_write_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_fire) begin
                        grant_b     <= pick_b;
                        last_grant  <= pick_b;
                        cur_wr      <= pick_wr;
                        m_address   <= pick_b ? b_address : a_address;
                        m_data_in   <= pick_b ? b_data_in : a_data_in;
                        m_write_req <= pick_wr;
                        m_read_req  <= !pick_wr;
                    end
                end
                BUSY: begin
                    if (done) begin
                        m_read_req  <= 1'b0;
                        m_write_req <= 1'b0;
                        if (grant_b) begin
                            b_write_ack <= cur_wr;
                            b_read_ack  <= !cur_wr;
                        end else begin
                            a_write_ack <= cur_wr;
                            a_read_ack  <= !cur_wr;
                        end
                        if (load_rdata) begin
                            if (grant_b) b_data_out <= m_data_out;
                            else         a_data_out <= m_data_out;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int TMO_LOG = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TMO_W   = (TMO_LOG > 10) ? TMO_LOG : 10;

    logic [TMO_W-1:0] tmo_cnt;

    // Counter holds zero outside BUSY, so it restarts on every BUSY entry.
    assign timeout_hit = (state == BUSY) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmo_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            tmo_cnt <= (state == BUSY) ? tmo_cnt + 1'b1 : '0;
            if (timeout_hit && !op_ack) err_timeout <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: directed requester traffic against a simple controller model.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;
`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 1023;
`endif

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [AW-1:0] a_address, b_address, m_address;
    logic [DW-1:0] a_data_in, b_data_in, a_data_out, b_data_out, m_data_in, m_data_out;
    logic          a_read_req, a_write_req, a_read_ack, a_write_ack;
    logic          b_read_req, b_write_req, b_read_ack, b_write_ack;
    logic          m_read_req, m_write_req, m_read_ack, m_write_ack;
    logic          busy, grant_b, err_timeout;

    sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .a_address(a_address), .a_data_in(a_data_in), .a_read_req(a_read_req),
        .a_write_req(a_write_req), .a_read_ack(a_read_ack), .a_write_ack(a_write_ack),
        .a_data_out(a_data_out),
        .b_address(b_address), .b_data_in(b_data_in), .b_read_req(b_read_req),
        .b_write_req(b_write_req), .b_read_ack(b_read_ack), .b_write_ack(b_write_ack),
        .b_data_out(b_data_out),
        .m_address(m_address), .m_data_in(m_data_in), .m_read_req(m_read_req),
        .m_write_req(m_write_req), .m_read_ack(m_read_ack), .m_write_ack(m_write_ack),
        .m_data_out(m_data_out),
        .busy(busy), .grant_b(grant_b), .err_timeout(err_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc++;

    typedef struct {bit b; bit wr; logic [AW-1:0] addr; logic [DW-1:0] data;} grant_t;
    typedef struct {bit b; bit wr; logic [DW-1:0] dout;} ack_t;

    grant_t gq[$];
    ack_t   aq[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired, got no response, required one", name);
    endtask

    task automatic expect_txn(input bit b, input bit wr, input logic [AW-1:0] ad,
                              input logic [DW-1:0] dd, input logic [DW-1:0] dout);
        gq.push_back('{b, wr, ad, dd});
        aq.push_back('{b, wr, dout});
    endtask

    function automatic logic ack_of(input bit b, input bit wr);
        return b ? (wr ? b_write_ack : b_read_ack) : (wr ? a_write_ack : a_read_ack);
    endfunction

    // Controller model: acks ctl_delay cycles after the request, optional stray opposite-type ack
    int          ctl_delay = 2;
    bit          ctl_stray = 1'b0;
    bit          ctl_never = 1'b0;
    int          ctl_ack_cyc = -10;
    logic [DW-1:0] mem [logic [AW-1:0]];

    task automatic ctl_serve();
        bit            wr;
        logic [AW-1:0] ad;
        logic [DW-1:0] dd;
        int unsigned   n;
        wr = m_write_req;
        ad = m_address;
        dd = m_data_in;
        n  = 1;
        while (n < ctl_delay) begin
            if (ctl_stray && n == 1) begin
                m_read_ack  = wr;
                m_write_ack = !wr;
            end
            @(negedge sys_clk);
            m_read_ack  = 1'b0;
            m_write_ack = 1'b0;
            if (!(m_read_req || m_write_req)) return;
            n++;
        end
        if (wr) begin
            m_write_ack = 1'b1;
            mem[ad] = dd;
        end else begin
            m_read_ack = 1'b1;
            m_data_out = mem.exists(ad) ? mem[ad] : '0;
        end
        ctl_ack_cyc = cyc;
        @(negedge sys_clk);
        m_read_ack  = 1'b0;
        m_write_ack = 1'b0;
        m_data_out  = 16'hDEAD;
    endtask

    initial begin
        m_read_ack  = 1'b0;
        m_write_ack = 1'b0;
        m_data_out  = '0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n && (m_read_req || m_write_req) && !ctl_never) ctl_serve();
        end
    end

    // Monitor: pops the scoreboard on each new downstream grant and each requester ack
    bit       prev_mreq = 1'b0;
    int       low_run = 100;
    bit       mreq;
    logic [3:0] acks;
    grant_t   mg;
    ack_t     ma;

    always @(negedge sys_clk) begin
        mreq = m_read_req | m_write_req;
        acks = {a_read_ack, a_write_ack, b_read_ack, b_write_ack};
        if (sys_rst_n) begin
            if (mreq && !prev_mreq) begin
                if (gq.size() == 0) begin
                    chk("unexpected_grant", {grant_b, m_write_req, m_address}, 0);
                end else begin
                    mg = gq.pop_front();
                    chk("grant", {grant_b, m_write_req, m_read_req, m_address, m_data_in},
                        {mg.b, mg.wr, !mg.wr, mg.addr, mg.data});
                    chk("grant_gap", 64'(low_run >= 2), 1);
                end
            end
            if (acks != 4'b0) begin
                if (aq.size() == 0) begin
                    chk("unexpected_ack", acks, 0);
                end else begin
                    ma = aq.pop_front();
                    chk("ack_which", acks, {!ma.b && !ma.wr, !ma.b && ma.wr, ma.b && !ma.wr, ma.b && ma.wr});
                    chk("ack_dout", ma.b ? b_data_out : a_data_out, ma.dout);
                    if (!ctl_never) chk("ack_latency", cyc, ctl_ack_cyc + 1);
                end
            end
        end
        low_run   = mreq ? 0 : low_run + 1;
        prev_mreq = mreq;
    end

    task automatic wait_ack(input bit b, input bit wr, input string name);
        int unsigned n = 0;
        while (!ack_of(b, wr) && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 300) bound_fail(name);
    endtask

    task automatic wait_busy(input string name);
        int unsigned n = 0;
        while (!busy && n < 50) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 50) bound_fail(name);
    endtask

    task automatic do_req(input bit b, input bit wr, input logic [AW-1:0] ad, input logic [DW-1:0] dd);
        if (b) begin
            b_address = ad; b_data_in = dd;
            if (wr) b_write_req = 1'b1; else b_read_req = 1'b1;
        end else begin
            a_address = ad; a_data_in = dd;
            if (wr) a_write_req = 1'b1; else a_read_req = 1'b1;
        end
        wait_ack(b, wr, b ? "b_ack_wait" : "a_ack_wait");
        if (b) begin b_write_req = 1'b0; b_read_req = 1'b0; end
        else   begin a_write_req = 1'b0; a_read_req = 1'b0; end
        @(negedge sys_clk);
    endtask

    task automatic apply_reset();
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_watchdog: simulation time limit reached, got no finish, required one");
        $fatal(1, "global watchdog");
    end

    initial begin
        int gcyc;
        a_address = '0; a_data_in = '0; a_read_req = 1'b0; a_write_req = 1'b0;
        b_address = '0; b_data_in = '0; b_read_req = 1'b0; b_write_req = 1'b0;
        mem[24'h000100] = 16'h1234;
        mem[24'h000200] = 16'h5678;

        repeat (3) @(negedge sys_clk);
        chk("rst_ctrl", {m_read_req, m_write_req, busy, grant_b, err_timeout,
                         a_read_ack, a_write_ack, b_read_ack, b_write_ack}, 0);
        chk("rst_m_bus", {m_address, m_data_in}, 0);
        chk("rst_dout", {a_data_out, b_data_out}, 0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // A write, controller acks 5 cycles after the request
        ctl_delay = 5;
        expect_txn(0, 1, 24'h000010, 16'hBEEF, 16'h0000);
        do_req(0, 1, 24'h000010, 16'hBEEF);

        // Simultaneous reads from both ports right after reset: A first, then B
        apply_reset();
        ctl_delay = 3;
        expect_txn(0, 0, 24'h000100, 16'h0000, 16'h1234);
        expect_txn(1, 0, 24'h000200, 16'h0000, 16'h5678);
        fork
            do_req(0, 0, 24'h000100, 16'h0000);
            do_req(1, 0, 24'h000200, 16'h0000);
        join
        chk("a_dout_held", a_data_out, 16'h1234);

        // Both ports continuously pending: A,B alternation, stray opposite acks ignored
        ctl_stray = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_txn(0, 1, 24'h000300 + 24'(i), 16'h1000 + 16'(i), 16'h1234);
            expect_txn(1, 0, 24'h000200, 16'h0000, 16'h5678);
        end
        fork
            for (int i = 0; i < 3; i++) do_req(0, 1, 24'h000300 + 24'(i), 16'h1000 + 16'(i));
            for (int j = 0; j < 3; j++) do_req(1, 0, 24'h000200, 16'h0000);
        join
        ctl_stray = 1'b0;
        chk("fair_mem_wr", mem[24'h000302], 16'h1002);

        // A read and write together: write first, read returns the written word
        expect_txn(0, 1, 24'h000020, 16'hCAFE, 16'h1234);
        expect_txn(0, 0, 24'h000020, 16'hCAFE, 16'hCAFE);
        a_address = 24'h000020; a_data_in = 16'hCAFE;
        a_read_req = 1'b1; a_write_req = 1'b1;
        wait_ack(0, 1, "rw_write_ack_wait");
        a_write_req = 1'b0;
        wait_ack(0, 0, "rw_read_ack_wait");
        a_read_req = 1'b0;
        @(negedge sys_clk);

        // Reset while BUSY abandons the access; a later B request is served normally
        ctl_delay = 10;
        gq.push_back('{1'b1, 1'b0, 24'h000200, 16'h0000});
        b_address = 24'h000200; b_data_in = '0; b_read_req = 1'b1;
        wait_busy("rst_busy_wait");
        repeat (2) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("rst_abort", {m_read_req, m_write_req, busy, grant_b,
                          a_read_ack, a_write_ack, b_read_ack, b_write_ack}, 0);
        chk("rst_abort_dout", {a_data_out, b_data_out}, 0);
        b_read_req = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        ctl_delay = 2;
        expect_txn(1, 0, 24'h000200, 16'h0000, 16'h5678);
        do_req(1, 0, 24'h000200, 16'h0000);

`ifdef SDRAM_ARB_TIMEOUT_EN
        // Controller never answers: watchdog aborts after TMO BUSY cycles
        ctl_never = 1'b1;
        expect_txn(0, 0, 24'h000100, 16'h0000, 16'h0000);
        a_address = 24'h000100; a_data_in = '0; a_read_req = 1'b1;
        wait_busy("tmo_busy_wait");
        gcyc = cyc;
        wait_ack(0, 0, "tmo_ack_wait");
        chk("tmo_latency", cyc - gcyc, TMO);
        chk("tmo_flag", err_timeout, 1);
        a_read_req = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("tmo_sticky", {err_timeout, m_read_req, m_write_req}, 3'b100);
        ctl_never = 1'b0;
`else
        gcyc = cyc;
        chk("no_timeout_flag", err_timeout, 0);
`endif

        repeat (4) @(negedge sys_clk);
        chk("grant_queue_drained", gq.size(), 0);
        chk("ack_queue_drained", aq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
